// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types: instruction IDs, scalar width, vector context, dispatcher entry state
package core_pkg;

  localparam int InsnIDNum = 4;
  localparam int XLEN      = 32;

  typedef logic [XLEN-1:0] xlen_t;
  typedef logic [$clog2(InsnIDNum)-1:0] insn_id_t;

  typedef struct packed {
    logic [7:0] vl;
    logic [2:0] vsew;
    logic [2:0] vlmul;
  } vec_context_t;

  typedef enum logic [1:0] {
    FREE,
    ISSUED,
    COMMITTED
  } vdisp_state_e;

endpackage

// File: rtl/vinsn_id_ring.sv
// rtl/vinsn_id_ring.sv - head/commit/tail pointers and occupancy of the outstanding-ID ring
// The commit pointer is kept as a committed-entry count from head so a fully committed ring is unambiguous.
module vinsn_id_ring
  import core_pkg::*;
#(
  parameter int NrIds = InsnIDNum
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     alloc,
  input  logic     retire,
  input  logic     commit,
  input  logic     flush,
  output insn_id_t head,
  output insn_id_t tail,
  output insn_id_t commit_ptr,
  output logic     full
);

  localparam int CntW = $clog2(NrIds) + 1;

  insn_id_t        head_q, tail_q, head_d;
  logic [CntW-1:0] count_q, ncommit_q, count_d, ncommit_d;

  // An uncommitted head can only retire when illegal; the commit count then stays at zero.
  always_comb begin
    head_d    = head_q + insn_id_t'(retire);
    ncommit_d = ncommit_q + CntW'(commit) - CntW'(retire && (ncommit_q != '0));
    count_d   = count_q + CntW'(alloc) - CntW'(retire);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ncommit_q <= '0;
    end else begin
      head_q    <= head_d;
      ncommit_q <= ncommit_d;
      if (flush) begin
        tail_q  <= head_d + insn_id_t'(ncommit_d);
        count_q <= ncommit_d;
      end else begin
        tail_q  <= tail_q + insn_id_t'(alloc);
        count_q <= count_d;
      end
    end
  end

  assign head       = head_q;
  assign tail       = tail_q;
  assign commit_ptr = head_q + insn_id_t'(ncommit_q);
  assign full       = (count_q == CntW'(NrIds));

endmodule

// File: rtl/vinsn_dispatcher.sv
// rtl/vinsn_dispatcher.sv - vector instruction dispatcher: ID allocation, issue, commit, in-order retire, flush
// Optional VDISP_ILLEGAL_FLUSH_EN: retiring an illegal entry also flushes all younger uncommitted work.
module vinsn_dispatcher
  import core_pkg::*;
#(
  parameter int NrIds = InsnIDNum
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [31:0]  req_insn_i,
  input  xlen_t        req_scalar_i,
  input  vec_context_t req_vec_context_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [31:0]  insn_o,
  output insn_id_t     insn_id_o,
  output xlen_t        scalar_reg_o,
  output vec_context_t vec_context_o,
  input  logic         commit_req_i,
  output logic         insn_can_commit_o,
  output insn_id_t     insn_can_commit_id_o,
  input  logic         flush_i,
  output logic         flush_o,
  input  logic         done_i,
  input  insn_id_t     done_insn_id_i,
  input  logic         illegal_insn_i,
  output logic         retire_valid_o,
  output insn_id_t     retire_id_o,
  output logic         retire_illegal_o
);

  vdisp_state_e   state_q [NrIds];
  vdisp_state_e   state_d [NrIds];
  logic [NrIds-1:0] done_q, done_d, ill_q, ill_d;

  insn_id_t head, tail, commit_ptr;
  logic     full;
  logic     retire_fire, illegal_flush, flush_any, commit_fire, issue_fire, accept;

  // An illegal head that is not yet committed dies with an external flush, so it cannot retire then.
  assign retire_fire = done_q[head] &&
                       (state_q[head] == COMMITTED || (ill_q[head] && !flush_i));
`ifdef VDISP_ILLEGAL_FLUSH_EN
  assign illegal_flush = retire_fire && ill_q[head];
`else
  assign illegal_flush = 1'b0;
`endif
  assign flush_any   = flush_i || illegal_flush;
  assign commit_fire = commit_req_i && !flush_any && (state_q[commit_ptr] == ISSUED) &&
                       !(retire_fire && commit_ptr == head);
  assign issue_fire  = valid_o && ready_i && !flush_any;
  assign req_ready_o = !rst_i && !flush_any && !(full && !retire_fire) && (!valid_o || ready_i);
  assign accept      = req_valid_i && req_ready_o;

  vinsn_id_ring #(.NrIds(NrIds)) i_ring (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .alloc      (accept),
    .retire     (retire_fire),
    .commit     (commit_fire),
    .flush      (flush_any),
    .head       (head),
    .tail       (tail),
    .commit_ptr (commit_ptr),
    .full       (full)
  );

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    ill_d   = ill_q;
    if (issue_fire) state_d[insn_id_o] = ISSUED;
    if (commit_fire) state_d[commit_ptr] = COMMITTED;
    if (done_i && state_q[done_insn_id_i] != FREE) begin
      done_d[done_insn_id_i] = 1'b1;
      ill_d[done_insn_id_i]  = illegal_insn_i;
    end
    if (retire_fire) begin
      state_d[head] = FREE;
      done_d[head]  = 1'b0;
      ill_d[head]   = 1'b0;
    end
    if (flush_any) begin
      for (int i = 0; i < NrIds; i++) begin
        if (state_d[i] != COMMITTED) begin
          state_d[i] = FREE;
          done_d[i]  = 1'b0;
          ill_d[i]   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrIds; i++) state_q[i] <= FREE;
      done_q <= '0;
      ill_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
    end
  end

  // Issue register: payload only reloads once the previous one has been taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o       <= 1'b0;
      insn_o        <= '0;
      insn_id_o     <= '0;
      scalar_reg_o  <= '0;
      vec_context_o <= '0;
    end else if (flush_any) begin
      valid_o <= 1'b0;
    end else if (accept) begin
      valid_o       <= 1'b1;
      insn_o        <= req_insn_i;
      insn_id_o     <= tail;
      scalar_reg_o  <= req_scalar_i;
      vec_context_o <= req_vec_context_i;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      insn_can_commit_o    <= 1'b0;
      insn_can_commit_id_o <= '0;
      retire_valid_o       <= 1'b0;
      retire_id_o          <= '0;
      retire_illegal_o     <= 1'b0;
      flush_o              <= 1'b0;
    end else begin
      insn_can_commit_o    <= commit_fire;
      insn_can_commit_id_o <= commit_ptr;
      retire_valid_o       <= retire_fire;
      retire_id_o          <= head;
      retire_illegal_o     <= retire_fire && ill_q[head];
      flush_o              <= flush_any;
    end
  end

endmodule

// File: tb/tb_vinsn_dispatcher.sv
// tb/tb_vinsn_dispatcher.sv - scoreboard bench for vinsn_dispatcher with NrIds=4 directed scenarios
module tb_vinsn_dispatcher;
  import core_pkg::*;

  logic         clk, rst_i;
  logic         req_valid_i, req_ready_o;
  logic [31:0]  req_insn_i;
  xlen_t        req_scalar_i;
  vec_context_t req_vec_context_i;
  logic         valid_o, ready_i;
  logic [31:0]  insn_o;
  insn_id_t     insn_id_o;
  xlen_t        scalar_reg_o;
  vec_context_t vec_context_o;
  logic         commit_req_i, insn_can_commit_o;
  insn_id_t     insn_can_commit_id_o;
  logic         flush_i, flush_o;
  logic         done_i, illegal_insn_i;
  insn_id_t     done_insn_id_i;
  logic         retire_valid_o, retire_illegal_o;
  insn_id_t     retire_id_o;

  vinsn_dispatcher #(.NrIds(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_insn_i(req_insn_i), .req_scalar_i(req_scalar_i), .req_vec_context_i(req_vec_context_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .insn_o(insn_o), .insn_id_o(insn_id_o), .scalar_reg_o(scalar_reg_o), .vec_context_o(vec_context_o),
    .commit_req_i(commit_req_i), .insn_can_commit_o(insn_can_commit_o),
    .insn_can_commit_id_o(insn_can_commit_id_o),
    .flush_i(flush_i), .flush_o(flush_o),
    .done_i(done_i), .done_insn_id_i(done_insn_id_i), .illegal_insn_i(illegal_insn_i),
    .retire_valid_o(retire_valid_o), .retire_id_o(retire_id_o), .retire_illegal_o(retire_illegal_o)
  );

  typedef struct packed {
    logic [31:0]  insn;
    insn_id_t     id;
    xlen_t        scalar;
    vec_context_t ctx;
  } iss_t;

  typedef struct packed {
    insn_id_t id;
    logic     ill;
  } ret_t;

  iss_t     exp_iss[$];
  insn_id_t exp_cmt[$];
  ret_t     exp_ret[$];
  logic     exp_flush[$];
  int       n_checks = 0;
  int       n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output event.
  initial begin
    iss_t e;
    ret_t r;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        if (valid_o && ready_i) begin
          if (exp_iss.size() == 0) chk("unexpected issue", {32'h0, insn_o}, 64'hdead);
          else begin
            e = exp_iss.pop_front();
            chk("issue insn", insn_o, e.insn);
            chk("issue id", insn_id_o, e.id);
            chk("issue scalar", scalar_reg_o, e.scalar);
            chk("issue ctx", vec_context_o, e.ctx);
          end
        end
        if (insn_can_commit_o) begin
          if (exp_cmt.size() == 0) chk("unexpected commit", insn_can_commit_id_o, 64'hdead);
          else chk("commit id", insn_can_commit_id_o, exp_cmt.pop_front());
        end
        if (retire_valid_o) begin
          if (exp_ret.size() == 0) chk("unexpected retire", {retire_id_o, retire_illegal_o}, 64'hdead);
          else begin
            r = exp_ret.pop_front();
            chk("retire id", retire_id_o, r.id);
            chk("retire illegal", retire_illegal_o, r.ill);
          end
        end
        if (flush_o) begin
          if (exp_flush.size() == 0) chk("unexpected flush_o", flush_o, 0);
          else chk("flush_o", flush_o, exp_flush.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; req_valid_i = 1'b0; commit_req_i = 1'b0; flush_i = 1'b0; done_i = 1'b0;
    illegal_insn_i = 1'b0; ready_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst valid_o", valid_o, 0);
    chk("rst req_ready_o", req_ready_o, 0);
    chk("rst insn_can_commit_o", insn_can_commit_o, 0);
    chk("rst retire_valid_o", retire_valid_o, 0);
    chk("rst flush_o", flush_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("post-rst req_ready_o", req_ready_o, 1);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] insn, input insn_id_t id);
    int k;
    iss_t e;
    req_valid_i = 1'b1;
    req_insn_i = insn;
    req_scalar_i = insn ^ 32'h5a5a0000;
    req_vec_context_i = vec_context_t'(insn[13:0]);
    k = 0;
    @(negedge clk);
    while (!req_ready_o && k < 50) begin
      k++;
      @(negedge clk);
    end
    if (!req_ready_o) chk("send timeout req_ready_o", req_ready_o, 1);
    else begin
      e.insn = insn; e.id = id; e.scalar = req_scalar_i; e.ctx = req_vec_context_i;
      exp_iss.push_back(e);
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic commit(input insn_id_t id);
    commit_req_i = 1'b1;
    exp_cmt.push_back(id);
    @(posedge clk); #1;
    commit_req_i = 1'b0;
  endtask

  task automatic done(input insn_id_t id, input logic ill);
    done_i = 1'b1; done_insn_id_i = id; illegal_insn_i = ill;
    @(posedge clk); #1;
    done_i = 1'b0; illegal_insn_i = 1'b0;
  endtask

  task automatic expect_retire(input insn_id_t id, input logic ill);
    ret_t r;
    r.id = id; r.ill = ill;
    exp_ret.push_back(r);
  endtask

  task automatic flush_pulse(input logic with_commit);
    flush_i = 1'b1; commit_req_i = with_commit;
    exp_flush.push_back(1'b1);
    @(posedge clk); #1;
    flush_i = 1'b0; commit_req_i = 1'b0;
    @(negedge clk);
    chk("flush_o next cycle", flush_o, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_o one pulse", flush_o, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_insn_i = '0; req_scalar_i = '0; req_vec_context_i = '0;
    ready_i = 1'b1; commit_req_i = 1'b0; flush_i = 1'b0; done_i = 1'b0; done_insn_id_i = '0;
    illegal_insn_i = 1'b0;

    // Fill all four IDs, fifth stalls until ID 0 retires, then reuses ID 0
    do_reset();
    send(32'h0000_1000, 2'd0);
    send(32'h0000_1001, 2'd1);
    send(32'h0000_1002, 2'd2);
    send(32'h0000_1003, 2'd3);
    req_valid_i = 1'b1; req_insn_i = 32'h0000_1004;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full stall req_ready_o", req_ready_o, 0);
      @(posedge clk); #1;
    end
    req_valid_i = 1'b0;
    commit(2'd0);
    expect_retire(2'd0, 1'b0);
    done(2'd0, 1'b0);
    idle(3);
    send(32'h0000_1004, 2'd0);
    idle(2);

    // Backpressure: payload held stable for 3 stalled cycles
    do_reset();
    ready_i = 1'b0;
    send(32'h0000_2abc, 2'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall valid_o", valid_o, 1);
      chk("stall insn_o", insn_o, 32'h0000_2abc);
      chk("stall insn_id_o", insn_id_o, 0);
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("valid_o drops after transfer", valid_o, 0);
    @(posedge clk); #1;

    // In-order commit and retire with out-of-order completion
    do_reset();
    send(32'h0000_3000, 2'd0);
    send(32'h0000_3001, 2'd1);
    idle(2);
    commit(2'd0);
    commit(2'd1);
    expect_retire(2'd0, 1'b0);
    expect_retire(2'd1, 1'b0);
    done(2'd1, 1'b0);
    idle(2);
    done(2'd0, 1'b0);
    idle(5);

    // Flush keeps committed ID 0, frees 1 and 2, next request gets ID 1
    do_reset();
    send(32'h0000_4000, 2'd0);
    send(32'h0000_4001, 2'd1);
    send(32'h0000_4002, 2'd2);
    idle(2);
    commit(2'd0);
    idle(1);
    flush_pulse(1'b0);
    send(32'h0000_4003, 2'd1);
    idle(2);
    commit(2'd1);
    expect_retire(2'd0, 1'b0);
    expect_retire(2'd1, 1'b0);
    done(2'd0, 1'b0);
    done(2'd1, 1'b0);
    idle(5);

    // Illegal completion of uncommitted ID 0
    do_reset();
    send(32'h0000_5000, 2'd0);
    send(32'h0000_5001, 2'd1);
    idle(2);
    expect_retire(2'd0, 1'b1);
`ifdef VDISP_ILLEGAL_FLUSH_EN
    exp_flush.push_back(1'b1);
    done(2'd0, 1'b1);
    idle(4);
    send(32'h0000_5002, 2'd1);
    idle(3);
`else
    done(2'd0, 1'b1);
    idle(4);
    commit(2'd1);
    expect_retire(2'd1, 1'b0);
    done(2'd1, 1'b0);
    idle(5);
`endif

    // Flush coinciding with commit_req: no commit; done for flushed ID 2 ignored
    do_reset();
    send(32'h0000_6000, 2'd0);
    send(32'h0000_6001, 2'd1);
    send(32'h0000_6002, 2'd2);
    idle(2);
    commit(2'd0);
    flush_pulse(1'b1);
    done(2'd2, 1'b0);
    idle(3);
    expect_retire(2'd0, 1'b0);
    done(2'd0, 1'b0);
    idle(4);
    send(32'h0000_6003, 2'd1);
    idle(4);

    chk("leftover issue expectations", exp_iss.size(), 0);
    chk("leftover commit expectations", exp_cmt.size(), 0);
    chk("leftover retire expectations", exp_ret.size(), 0);
    chk("leftover flush expectations", exp_flush.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vinsn_dispatcher.md
VINSN_DISPATCHER -- requirements
Module: vinsn_dispatcher

Interface
REQ-001 SHALL have parameter NrIds, default core_pkg::InsnIDNum, giving the outstanding-instruction capacity (power of two, >=2).
REQ-002 SHALL have clk_i, in, 1, the only clock.
REQ-003 SHALL have rst_i, in, 1, reset: synchronous, active-high.
REQ-004 SHALL have req_valid_i / req_ready_o, in/out, 1/1, scalar-pipeline vector-instruction handshake.
REQ-005 SHALL have req_insn_i / req_scalar_i / req_vec_context_i, in, 32 / xlen_t / vec_context_t, instruction payload.
REQ-006 SHALL have valid_o / ready_i, out/in, 1/1, issue handshake toward the vector core.
REQ-007 SHALL have insn_o / insn_id_o / scalar_reg_o / vec_context_o, out, 32 / insn_id_t / xlen_t / vec_context_t, issued payload.
REQ-008 SHALL have commit_req_i, in, 1, scalar ROB marks the oldest uncommitted vector instruction non-speculative.
REQ-009 SHALL have insn_can_commit_o / insn_can_commit_id_o, out, 1 / insn_id_t, commit permission toward the vector core.
REQ-010 SHALL have flush_i / flush_o, in/out, 1/1, squash request in / squash forwarded to the vector core.
REQ-011 SHALL have done_i / done_insn_id_i / illegal_insn_i, in, 1 / insn_id_t / 1, completion report from the vector core.
REQ-012 SHALL have retire_valid_o / retire_id_o / retire_illegal_o, out, 1 / insn_id_t / 1, in-order retirement toward the scalar core.

Function
REQ-013 SHALL allocate IDs sequentially from 0, wrapping modulo NrIds; per-entry state FREE, ISSUED, COMMITTED, plus a done flag and an illegal flag.
REQ-014 SHALL register an accepted request into a one-entry issue register; valid_o asserts the cycle after acceptance (latency 1).
REQ-015 SHALL drive req_ready_o = !full && (!valid_o || ready_i); full means NrIds entries are non-FREE, counting the issue register.
REQ-016 SHALL hold the issue payload stable while valid_o && !ready_i; on valid_o && ready_i the entry moves to ISSUED.
REQ-017 SHALL pulse insn_can_commit_o for one cycle with the oldest ISSUED ID when commit_req_i is high, then mark that entry COMMITTED; at most one commit per cycle, in allocation order.
REQ-018 SHALL set the done and illegal flags on done_i for a non-FREE ID, and ignore done_i for a FREE ID.
REQ-019 SHALL retire the head entry when done && (COMMITTED || illegal): retire_valid_o pulses one cycle with its ID and flag, the entry becomes FREE, and the head advances; latency is at least 1 cycle after done_i.
REQ-020 SHALL treat flush_i as follows: flush_o is registered (one-cycle pulse next cycle); every non-COMMITTED entry and the issue register are freed; the tail rewinds to just past the youngest COMMITTED entry.
REQ-021 SHALL give flush_i priority when it coincides with commit_req_i: no commit is issued that cycle.
REQ-022 SHALL give flush_i priority when it coincides with an accepted request: the request is dropped and req_ready_o is low that cycle.
REQ-023 SHALL apply done_i and retirement in the same cycle as a flush to surviving entries only.
REQ-024 SHALL allow allocation of a freed entry in the same cycle it retires, with no bubble.

Reset
REQ-025 SHALL, while rst_i is high, drive all outputs 0, set every entry FREE, and zero the head/commit/tail pointers and next ID.
REQ-026 SHALL, on reset mid-operation, discard outstanding entries without retirement and without flush_o.

Configuration
REQ-027 SHALL, with VDISP_ILLEGAL_FLUSH_EN defined, have retiring an illegal entry internally raise a flush equivalent to flush_i in the same cycle.
REQ-028 SHALL, without VDISP_ILLEGAL_FLUSH_EN defined, retire illegal entries normally, with flushing only via flush_i.

Structure
REQ-029 SHALL place NrIds default InsnIDNum, insn_id_t, vec_context_t and a new vdisp_state_e enum {FREE, ISSUED, COMMITTED} in core_pkg.
REQ-030 SHALL implement the head/commit/tail pointers and occupancy count in one sub-module, vinsn_id_ring.

Verification (NrIds=4)
REQ-031 SHALL cover: 4 back-to-back requests with ready_i=1 -> IDs 0,1,2,3 issued; a 5th stalls with req_ready_o=0 until ID 0 retires.
REQ-032 SHALL cover: ready_i=0 for 3 cycles with valid_o high -> payload and insn_id_o held stable; transfer on the first ready_i=1.
REQ-033 SHALL cover: IDs 0,1 issued, commit_req_i twice, done for ID1 then ID0 -> insn_can_commit 0,1; retirements in order 0 then 1.
REQ-034 SHALL cover: IDs 0..2 issued, ID0 committed, then flush_i -> flush_o next cycle; IDs 1,2 freed; next request gets ID 1.
REQ-035 SHALL cover: done_i with illegal for uncommitted ID 0 -> retire_illegal_o=1 for ID 0; with VDISP_ILLEGAL_FLUSH_EN, younger ID 1 is flushed.
REQ-036 SHALL cover: flush_i and commit_req_i in the same cycle -> no insn_can_commit_o pulse; done_i for the flushed ID 2 ignored.
